// File: rtl/fp_int_serial_mul.sv
// fp_int_serial_mul: bit-serial FP16 x INT-N multiplier with a systolic forwarding pipe.
// Define FP_INT_MUL_SIGNED_EN for two's-complement weights (MSB weighs -2^(p-1)).
//
// state | meaning
// IDLE  | waiting for the first bit of a group
// ACC   | group in progress, accumulating one weight bit per valid cycle
module fp_int_serial_mul #(
  parameter int ACT_WIDTH = 16,
  parameter int W_MAX     = 8,
  parameter int FWD_DELAY = 1,
  parameter int MW        = 11 + W_MAX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [ACT_WIDTH-1:0] act,
  input  logic                 w,
  input  logic [3:0]           precision,
  output logic                 out_valid,
  output logic                 sign_out,
  output logic [4:0]           exp_out,
  output logic [MW-1:0]        mant_out,
  output logic                 abort,
  output logic                 busy,
  output logic [ACT_WIDTH-1:0] act_fwd,
  output logic                 w_fwd,
  output logic                 valid_fwd
);

  localparam logic [3:0] W_MAX_P = 4'(W_MAX);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         eff_p_in, eff_p_q, eff_p_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic [4:0]         exp_q, exp_d;
  logic [10:0]        m_q, m_d;
  logic signed [MW:0] acc_q, acc_d, addend;
  logic               done, abort_d, acc_neg, res_zero;
  logic [MW-1:0]      res_mag;

  always_comb begin
    if (precision == 4'd0) begin
      eff_p_in = 4'd1;
    end else if (precision > W_MAX_P) begin
      eff_p_in = W_MAX_P;
    end else begin
      eff_p_in = precision;
    end
  end

  always_comb begin
    state_d = state_q;
    eff_p_d = eff_p_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    m_d     = m_q;
    acc_d   = acc_q;
    addend  = '0;
    done    = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          eff_p_d = eff_p_in;
          cnt_d   = 4'd1;
          sign_d  = act[ACT_WIDTH-1];
          exp_d   = (act[14:10] == 5'd0) ? 5'd1 : act[14:10];
          m_d     = {act[14:10] != 5'd0, act[9:0]};
          addend  = w ? (MW+1)'(m_d) : '0;
`ifdef FP_INT_MUL_SIGNED_EN
          acc_d   = -addend;
`else
          acc_d   = addend;
`endif
          if (eff_p_in == 4'd1) begin
            done = 1'b1;
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (in_valid) begin
          cnt_d  = cnt_q + 4'd1;
          addend = w ? (MW+1)'(m_q) : '0;
          acc_d  = (acc_q <<< 1) + addend;
          if (cnt_d == eff_p_q) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          abort_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Magnitude always fits MW bits: |m * w| < 2^11 * 2^W_MAX.
  always_comb begin
    acc_neg  = acc_d[MW];
    res_mag  = acc_neg ? MW'(-acc_d) : MW'(acc_d);
    res_zero = (res_mag == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      eff_p_q   <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      m_q       <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      abort     <= 1'b0;
      sign_out  <= 1'b0;
      exp_out   <= '0;
      mant_out  <= '0;
    end else begin
      state_q   <= state_d;
      eff_p_q   <= eff_p_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      out_valid <= done;
      abort     <= abort_d;
      if (done) begin
        mant_out <= res_mag;
        sign_out <= res_zero ? 1'b0 : (sign_d ^ acc_neg);
        exp_out  <= res_zero ? 5'd0 : exp_d;
      end
    end
  end

  assign busy = (state_q == ACC);

  logic [ACT_WIDTH+1:0] fwd_pipe [FWD_DELAY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FWD_DELAY; i++) begin
        fwd_pipe[i] <= '0;
      end
    end else begin
      fwd_pipe[0] <= {act, w, in_valid};
      for (int i = 1; i < FWD_DELAY; i++) begin
        fwd_pipe[i] <= fwd_pipe[i-1];
      end
    end
  end

  assign {act_fwd, w_fwd, valid_fwd} = fwd_pipe[FWD_DELAY-1];

endmodule

// File: doc/fp_int_serial_mul.md
# fp_int_serial_mul

Parametrised bit-serial FP16 × INT-N multiplier for the FP-INT MAC array.
- Each processing element receives one FP16 activation per weight group and the weight serially, MSB first, one bit per cycle. Group length is the runtime precision, 1..W_MAX bits.
- It emits the exact product as sign, biased exponent and a fixed-point mantissa magnitude, ready for the downstream FP accumulator.
- Activation, weight bit and valid are forwarded to the neighbouring element with a configurable delay, forming the systolic chain.

## Interface
Parameters:
- ACT_WIDTH, 16, activation width (FP16: 1 sign, 5 exponent, 10 mantissa; fixed).
- W_MAX, 8, maximum weight precision in bits, 2..8.
- FWD_DELAY, 1, forwarding delay in cycles, ≥1.
- MW, 11+W_MAX (derived), product mantissa width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  weight bit valid; must stay high for a whole group.
- act  in  ACT_WIDTH  FP16 activation, sampled on the first bit of a group.
- w  in  1  serial weight bit, MSB first.
- precision  in  4  group length, sampled on the first bit.
- out_valid  out  1  one-cycle product strobe.
- sign_out  out  1  product sign.
- exp_out  out  5  product biased exponent.
- mant_out  out  MW  product magnitude, binary point after bit 10.
- abort  out  1  one-cycle pulse when a group is truncated.
- busy  out  1  high while a group is in progress.
- act_fwd  out  ACT_WIDTH  act delayed FWD_DELAY cycles.
- w_fwd  out  1  w delayed FWD_DELAY cycles.
- valid_fwd  out  1  in_valid delayed FWD_DELAY cycles.

Reset value of every output is 0.

## Operation
States:
- IDLE. A cycle with in_valid=1 is the first bit of a group. On it, latch act, latch eff_p, set cnt=1 and go to ACC. If eff_p=1, complete immediately and stay in IDLE.
- ACC. Each cycle with in_valid=1 accumulates one bit and increments cnt. When cnt reaches eff_p, the group completes and the FSM returns to IDLE.
- in_valid=0 while in ACC: pulse abort, discard the group, return to IDLE, no out_valid.

Precision and operand decode:
- eff_p = 1 if precision=0; W_MAX if precision>W_MAX; otherwise precision.
- Mantissa m = {1, frac} for exponent≠0. For exponent=0 (subnormal), m = {0, frac} and exp_out = 1.
- Infinity/NaN (exponent=31) are not checked; they pass as normal operands.

Accumulation:
- acc is MW+1 bits, two's complement, cleared at group start.
- Every bit does acc = (acc<<1) + (w ? m : 0).
- With signed weights, the first (MSB) bit instead contributes −m.

Result, registered on group completion:
- mant_out = |acc|.
- sign_out = act_sign XOR (acc<0).
- If |acc|=0, sign_out = 0 and exp_out = 0.
- Outputs hold until the next completion.
- No normalisation and no rounding; the result is exact.

Other rules:
- busy = state==ACC.
- Forwarding is a plain FWD_DELAY-stage shift register, independent of the FSM and of abort.

## Timing
- Group first bit at cycle t, last bit at t+eff_p−1. out_valid, sign_out, exp_out and mant_out update at the edge ending cycle t+eff_p−1, so they are visible during cycle t+eff_p.
- Back-to-back groups: the next first bit may arrive in cycle t+eff_p with no bubble. out_valid pulses once per completed group.
- Precision changes mid-group are ignored.
- Abort: pulse is visible in the cycle after the in_valid=0 cycle. If in_valid=1 in the same cycle as the abort decision, that is impossible: an abort is by definition a low cycle.
- Asserting rst mid-group clears the FSM, acc and all outputs asynchronously, and empties the forwarding pipe. After rst falls, the first in_valid=1 is a new group.

## Configuration
- FP_INT_MUL_SIGNED_EN defined: weights are two's complement and the MSB carries weight −2^(eff_p−1).
- Not defined: weights are unsigned, the MSB is positive, and sign_out = act_sign (0 when the product is zero).
- Width rules are unchanged either way.

## Test plan
Values below assume W_MAX=8, FWD_DELAY=1 and FP_INT_MUL_SIGNED_EN defined.
- act=0x3C00, precision=4, bits 0101 → out_valid 4 cycles after the first bit; mant_out=0x1400, exp_out=15, sign_out=0.
- act=0x3C00, precision=4, bits 1101 (−3) → mant_out=0xC00, sign_out=1. With FP_INT_MUL_SIGNED_EN undefined (13) → mant_out=0x3400, sign_out=0.
- act=0xBC00, precision=2, bits 11 (−1) → mant_out=0x400, sign_out=0. Subnormal act=0x0001, precision=3, bits 011 → mant_out=3, exp_out=1.
- Two groups back-to-back, precision=3 then precision=5, no bubble → exactly two out_valid pulses, 3 and 5 cycles apart, with correct values. precision=0 → treated as 1-bit groups; precision=12 → treated as 8.
- in_valid drops after 2 of 4 bits → abort pulses once, no out_valid, previous outputs held. A new group immediately after it completes correctly.
- rst pulsed mid-group → all outputs 0 at once. act_fwd/w_fwd/valid_fwd match the inputs one cycle later throughout.
